// File: rtl/prediction_validation_queue.sv
// Branch prediction finalisation with an in-order validation queue.
// Predictions are registered out, queued, and checked against resolved next PCs.
module prediction_validation_queue #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter bit GATE_ON_HIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pred_valid,
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    gskew_prediction,
  input  logic                    hit,
  input  logic [ADDR_W-1:0]       btb_target,
  output logic                    pred_ready,
  output logic                    final_valid,
  output logic                    final_prediction,
  output logic [ADDR_W-1:0]       final_target,
  input  logic                    resolve_valid,
  input  logic [ADDR_W-1:0]       resolve_next_pc,
  output logic                    mispredict,
  output logic [ADDR_W-1:0]       redirect_pc,
  output logic [CNT_W-1:0]        correct_count,
  output logic [CNT_W-1:0]        mispredict_count,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    resolve_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [ADDR_W-1:0] fall_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] head_pc;
  logic              taken;
  logic              full;
  logic              empty;
  logic              accept;
  logic              do_resolve;
  logic              mis;
  logic              push;

  assign fall_pc = pc + ADDR_W'(4);

  // Direction and target selection; both modes yield the same decision,
  // mode 0 only differs in where the target source is chosen.
  generate
    if (GATE_ON_HIT) begin : g_gate
      assign taken   = gskew_prediction & hit;
      assign next_pc = taken ? btb_target : fall_pc;
    end else begin : g_sel
      logic [ADDR_W-1:0] taken_pc;
      assign taken_pc = hit ? btb_target : fall_pc;
      assign taken    = gskew_prediction & hit;
      assign next_pc  = gskew_prediction ? taken_pc : fall_pc;
    end
  endgenerate

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  assign occupancy  = wr_ptr - rd_ptr;
  assign pred_ready = ~full;

  assign accept     = pred_valid & pred_ready;
  assign do_resolve = resolve_valid & ~empty;
  assign head_pc    = mem[rd_ptr[IDX_W-1:0]];
  assign mis        = do_resolve & (head_pc != resolve_next_pc);
  // A mispredicting resolve discards any same-cycle (younger) prediction.
  assign push       = accept & ~mis;

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= next_pc;
    end
  end

  // Pointers, registered prediction/resolve outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      final_valid      <= 1'b0;
      final_prediction <= 1'b0;
      final_target     <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      correct_count    <= '0;
      mispredict_count <= '0;
      resolve_error    <= 1'b0;
    end else begin
      final_valid <= push;
      mispredict  <= mis;

      if (push) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        final_prediction <= taken;
        final_target     <= next_pc;
      end

      if (mis) begin
        rd_ptr      <= wr_ptr;
        redirect_pc <= resolve_next_pc;
        if (mispredict_count != CNT_MAX) begin
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end else if (do_resolve) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (correct_count != CNT_MAX) begin
          correct_count <= correct_count + CNT_W'(1);
        end
      end

      if (resolve_valid && empty) begin
        resolve_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prediction_validation_queue.sv
// Bench for prediction_validation_queue: reference queue model plus
// a scoreboard of expected registered predictions.
module tb_prediction_validation_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        gskew_prediction = 1'b0;
  logic        hit = 1'b0;
  logic [31:0] btb_target = '0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_next_pc = '0;

  logic        pred_ready, final_valid, final_prediction;
  logic [31:0] final_target, redirect_pc;
  logic        mispredict, resolve_error;
  logic [1:0]  correct_count, mispredict_count;
  logic [3:0]  occupancy;

  logic        r0, v0, p0, m0, e0;
  logic [31:0] t0, rp0;
  logic [1:0]  cc0, mc0;
  logic [3:0]  oc0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        pred;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] q_model[$];
  logic        exp_fv = 1'b0;
  logic        exp_mis = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_redir = '0;
  logic [1:0]  exp_cc = '0;
  logic [1:0]  exp_mc = '0;

  prediction_validation_queue #(
    .ADDR_W(32), .DEPTH(8), .CNT_W(2), .GATE_ON_HIT(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pc(pc),
    .gskew_prediction(gskew_prediction), .hit(hit),
    .btb_target(btb_target), .pred_ready(pred_ready),
    .final_valid(final_valid), .final_prediction(final_prediction),
    .final_target(final_target), .resolve_valid(resolve_valid),
    .resolve_next_pc(resolve_next_pc), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .correct_count(correct_count),
    .mispredict_count(mispredict_count), .occupancy(occupancy),
    .resolve_error(resolve_error)
  );

  prediction_validation_queue #(
    .ADDR_W(32), .DEPTH(8), .CNT_W(2), .GATE_ON_HIT(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pc(pc),
    .gskew_prediction(gskew_prediction), .hit(hit),
    .btb_target(btb_target), .pred_ready(r0),
    .final_valid(v0), .final_prediction(p0),
    .final_target(t0), .resolve_valid(resolve_valid),
    .resolve_next_pc(resolve_next_pc), .mispredict(m0),
    .redirect_pc(rp0), .correct_count(cc0),
    .mispredict_count(mc0), .occupancy(oc0),
    .resolve_error(e0)
  );

  always #5 clk = ~clk;

  task automatic set_pred(input logic [31:0] p, input logic g,
                          input logic h, input logic [31:0] t);
    pred_valid       = 1'b1;
    pc               = p;
    gskew_prediction = g;
    hit              = h;
    btb_target       = t;
  endtask

  // Advance one cycle, updating the reference model from the driven inputs.
  task automatic step();
    bit          acc, res, mis, tk;
    logic [31:0] nxt;
    if (reset) begin
      q_model.delete();
      sb.delete();
      exp_fv = 0; exp_mis = 0; exp_err = 0;
      exp_redir = '0; exp_cc = '0; exp_mc = '0;
    end else begin
      acc = pred_valid && (q_model.size() < 8);
      res = resolve_valid && (q_model.size() != 0);
      mis = res && (q_model[0] != resolve_next_pc);
      tk  = gskew_prediction & hit;
      nxt = tk ? btb_target : pc + 32'd4;
      exp_mis = mis;
      if (mis) exp_redir = resolve_next_pc;
      if (resolve_valid && q_model.size() == 0) exp_err = 1;
      if (res) begin
        if (mis) begin
          if (exp_mc != 2'd3) exp_mc++;
          q_model.delete();
        end else begin
          if (exp_cc != 2'd3) exp_cc++;
          void'(q_model.pop_front());
        end
      end
      exp_fv = acc && !mis;
      if (exp_fv) begin
        q_model.push_back(nxt);
        sb.push_back('{tk, nxt});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (pred_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", pred_ready);
    end
    checks++;
    if ({final_valid, final_prediction, mispredict, resolve_error} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b%b want 0000",
               final_valid, final_prediction, mispredict, resolve_error);
    end
    checks++;
    if (final_target !== 32'h0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pcs: got %h/%h want 0/0", final_target, redirect_pc);
    end
    checks++;
    if (correct_count !== 2'd0 || mispredict_count !== 2'd0 || occupancy !== 4'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0",
               correct_count, mispredict_count, occupancy);
    end
  endtask

  task automatic test_taken_hit();
    exp_t e;
    set_pred(32'h100, 1'b1, 1'b1, 32'h200);
    step();
    pred_valid = 1'b0;
    checks++;
    if (final_valid !== exp_fv || v0 !== exp_fv) begin
      errors++; $display("FAIL taken_valid: got %b/%b want %b", final_valid, v0, exp_fv);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (final_prediction !== e.pred || final_target !== e.tgt) begin
        errors++;
        $display("FAIL taken_pred: got %b %h want %b %h",
                 final_prediction, final_target, e.pred, e.tgt);
      end
      checks++;
      if (p0 !== e.pred || t0 !== e.tgt) begin
        errors++;
        $display("FAIL taken_pred_mode0: got %b %h want %b %h", p0, t0, e.pred, e.tgt);
      end
    end
    checks++;
    if (occupancy !== 4'(q_model.size())) begin
      errors++; $display("FAIL taken_occ: got %0d want %0d", occupancy, q_model.size());
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h200;
    step();
    resolve_valid = 1'b0;
    checks++;
    if (mispredict !== exp_mis || correct_count !== exp_cc) begin
      errors++;
      $display("FAIL taken_resolve: got %b %0d want %b %0d",
               mispredict, correct_count, exp_mis, exp_cc);
    end
    checks++;
    if (final_valid !== 1'b0 || final_target !== 32'h200) begin
      errors++;
      $display("FAIL taken_hold: got %b %h want 0 200", final_valid, final_target);
    end
  endtask

  task automatic test_miss_fallthrough();
    exp_t e;
    set_pred(32'h100, 1'b1, 1'b0, 32'h900);
    step();
    pred_valid = 1'b0;
    checks++;
    if (final_valid !== exp_fv) begin
      errors++; $display("FAIL miss_valid: got %b want %b", final_valid, exp_fv);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (final_prediction !== e.pred || final_target !== e.tgt ||
          p0 !== e.pred || t0 !== e.tgt) begin
        errors++;
        $display("FAIL miss_pred: got %b %h / %b %h want %b %h",
                 final_prediction, final_target, p0, t0, e.pred, e.tgt);
      end
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h104;
    step();
    resolve_valid = 1'b0;
    checks++;
    if (mispredict !== exp_mis || correct_count !== exp_cc || cc0 !== exp_cc) begin
      errors++;
      $display("FAIL miss_resolve: got %b %0d %0d want %b %0d",
               mispredict, correct_count, cc0, exp_mis, exp_cc);
    end
  endtask

  task automatic test_mispredict_flush();
    exp_t e;
    logic [31:0] pcs [3] = '{32'h100, 32'h300, 32'h3f0};
    logic        gs  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] tg  [3] = '{32'h200, 32'h880, 32'h400};
    for (int i = 0; i < 3; i++) begin
      set_pred(pcs[i], gs[i], 1'b1, tg[i]);
      step();
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (final_valid !== 1'b1 || final_target !== e.tgt) begin
          errors++;
          $display("FAIL flush_fill%0d: got %b %h want 1 %h", i, final_valid, final_target, e.tgt);
        end
      end
    end
    set_pred(32'h500, 1'b0, 1'b0, 32'h0);
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h204;
    step();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    checks++;
    if (mispredict !== exp_mis || redirect_pc !== exp_redir) begin
      errors++;
      $display("FAIL flush_mis: got %b %h want %b %h", mispredict, redirect_pc, exp_mis, exp_redir);
    end
    checks++;
    if (occupancy !== 4'(q_model.size()) || mispredict_count !== exp_mc) begin
      errors++;
      $display("FAIL flush_occ: got %0d %0d want %0d %0d",
               occupancy, mispredict_count, q_model.size(), exp_mc);
    end
    checks++;
    if (final_valid !== exp_fv) begin
      errors++; $display("FAIL flush_discard: got %b want %b", final_valid, exp_fv);
    end
    checks++;
    if (pred_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready: got %b want 1", pred_ready);
    end
    set_pred(32'h600, 1'b0, 1'b0, 32'h0);
    step();
    pred_valid = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (final_valid !== 1'b1 || final_target !== e.tgt || mispredict !== 1'b0) begin
        errors++;
        $display("FAIL flush_after: got %b %h %b want 1 %h 0",
                 final_valid, final_target, mispredict, e.tgt);
      end
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h604;
    step();
    resolve_valid = 1'b0;
  endtask

  task automatic test_full();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      set_pred(32'h1000 + 32'(i * 16), 1'b0, 1'b0, 32'h0);
      step();
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (final_valid !== 1'b1 || final_target !== e.tgt) begin
          errors++;
          $display("FAIL full_fill%0d: got %b %h want 1 %h", i, final_valid, final_target, e.tgt);
        end
      end
    end
    checks++;
    if (pred_ready !== 1'b0 || occupancy !== 4'd8) begin
      errors++; $display("FAIL full_state: got %b %0d want 0 8", pred_ready, occupancy);
    end
    set_pred(32'h2000, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (final_valid !== exp_fv || occupancy !== 4'(q_model.size())) begin
      errors++;
      $display("FAIL full_ignore: got %b %0d want %b %0d",
               final_valid, occupancy, exp_fv, q_model.size());
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = q_model[0];
    step();
    pred_valid = 1'b0;
    checks++;
    if (final_valid !== exp_fv || occupancy !== 4'd7 || pred_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_nobypass: got %b %0d %b want %b 7 1",
               final_valid, occupancy, pred_ready, exp_fv);
    end
    while (q_model.size() != 0) begin
      resolve_next_pc = q_model[0];
      step();
      checks++;
      if (mispredict !== exp_mis || correct_count !== exp_cc) begin
        errors++;
        $display("FAIL full_drain: got %b %0d want %b %0d",
                 mispredict, correct_count, exp_mis, exp_cc);
      end
    end
    resolve_valid = 1'b0;
    checks++;
    if (correct_count !== 2'd3) begin
      errors++; $display("FAIL cnt_saturate: got %0d want 3", correct_count);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    set_pred(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    step();
    pred_valid = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (final_target !== 32'h0 || e.tgt !== 32'h0 || final_prediction !== 1'b0) begin
        errors++;
        $display("FAIL wrap: got %b %h want 0 00000000", final_prediction, final_target);
      end
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h0;
    step();
    resolve_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b0 || occupancy !== 4'd0) begin
      errors++; $display("FAIL wrap_resolve: got %b %0d want 0 0", mispredict, occupancy);
    end
  endtask

  task automatic test_same_cycle_correct();
    exp_t e;
    set_pred(32'h700, 1'b0, 1'b0, 32'h0);
    step();
    if (sb.size() != 0) void'(sb.pop_front());
    set_pred(32'h800, 1'b0, 1'b0, 32'h0);
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h704;
    step();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    checks++;
    if (final_valid !== 1'b1 || occupancy !== 4'd1 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: got %b %0d %b want 1 1 0", final_valid, occupancy, mispredict);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (final_target !== e.tgt) begin
        errors++; $display("FAIL same_cycle_tgt: got %h want %h", final_target, e.tgt);
      end
    end
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h804;
    step();
    resolve_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 60; n++) begin
      pred_valid       = 1'($urandom_range(0, 1));
      pc               = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      gskew_prediction = 1'($urandom_range(0, 1));
      hit              = 1'($urandom_range(0, 1));
      btb_target       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      resolve_valid    = ($urandom_range(0, 2) == 0);
      if (q_model.size() != 0 && $urandom_range(0, 3) != 0)
        resolve_next_pc = q_model[0];
      else
        resolve_next_pc = $urandom;
      step();
      checks++;
      if (final_valid !== exp_fv || mispredict !== exp_mis) begin
        errors++;
        $display("FAIL b2b_pulse%0d: got %b %b want %b %b",
                 n, final_valid, mispredict, exp_fv, exp_mis);
      end
      checks++;
      if (occupancy !== 4'(q_model.size()) || correct_count !== exp_cc ||
          mispredict_count !== exp_mc || redirect_pc !== exp_redir) begin
        errors++;
        $display("FAIL b2b_state%0d: got %0d %0d %0d %h want %0d %0d %0d %h", n,
                 occupancy, correct_count, mispredict_count, redirect_pc,
                 q_model.size(), exp_cc, exp_mc, exp_redir);
      end
      if (final_valid && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (final_prediction !== e.pred || final_target !== e.tgt ||
            p0 !== e.pred || t0 !== e.tgt) begin
          errors++;
          $display("FAIL b2b_pred%0d: got %b %h / %b %h want %b %h", n,
                   final_prediction, final_target, p0, t0, e.pred, e.tgt);
        end
      end
    end
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic test_resolve_error();
    reset = 1'b1;
    step();
    reset = 1'b0;
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'h55;
    step();
    resolve_valid = 1'b0;
    checks++;
    if (resolve_error !== exp_err || e0 !== exp_err) begin
      errors++; $display("FAIL err_set: got %b %b want %b", resolve_error, e0, exp_err);
    end
    checks++;
    if (correct_count !== exp_cc || mispredict_count !== exp_mc ||
        mispredict !== 1'b0 || occupancy !== 4'd0) begin
      errors++;
      $display("FAIL err_nochange: got %0d %0d %b %0d want %0d %0d 0 0",
               correct_count, mispredict_count, mispredict, occupancy, exp_cc, exp_mc);
    end
    step();
    checks++;
    if (resolve_error !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", resolve_error);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_pred(32'h40 + 32'(i * 4), 1'b1, 1'b1, 32'hA00 + 32'(i * 16));
      step();
    end
    set_pred(32'h80, 1'b1, 1'b1, 32'hB00);
    resolve_valid   = 1'b1;
    resolve_next_pc = 32'hDEAD_0000;
    reset           = 1'b1;
    step();
    reset         = 1'b0;
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    checks++;
    if (final_valid !== 1'b0 || mispredict !== 1'b0 || occupancy !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_pulse: got %b %b %0d want 0 0 0", final_valid, mispredict, occupancy);
    end
    checks++;
    if (pred_ready !== 1'b1 || resolve_error !== 1'b0 || final_target !== 32'h0 ||
        correct_count !== 2'd0 || mispredict_count !== 2'd0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_state: got %b %b %h %0d %0d %h want 1 0 0 0 0 0",
               pred_ready, resolve_error, final_target, correct_count,
               mispredict_count, redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_taken_hit();
    test_miss_fallthrough();
    test_mispredict_flush();
    test_full();
    test_wrap();
    test_same_cycle_correct();
    test_back_to_back();
    test_resolve_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
